// File: rtl/seq_det_prog.sv
// Runtime-programmable serial bit-pattern detector with a saturating match counter.
// Define SEQ_DET_PROG_REG_OUT_EN to register the match strobe (one cycle later).
module seq_det_prog #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LEN_W-1:0]   cfg_len_q
);

  typedef logic [LEN_W:0] len_ext_t;

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               fill_ok;
  logic               hit;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;

  always_comb begin
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < 32'(len_q));
    end
  end

  always_comb begin
    accept  = in_valid & ~cfg_load;
    window  = {hist_q[MAX_LEN-2:0], in_bit};
    // At least len-1 bits since restart, so the current bit completes a fresh window.
    fill_ok = (len_ext_t'(fill_q) + len_ext_t'(1)) >= len_ext_t'(len_q);
    hit     = accept && (len_q != '0) && fill_ok && (((window ^ pat_q) & len_mask) == '0);
  end

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;

    if (cfg_load) begin
      pat_d  = cfg_pattern;
      ovl_d  = cfg_overlap;
      len_d  = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = window;
      if (hit && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q >= len_q) begin
        fill_d = len_q;
      end else begin
        fill_d = fill_q + LEN_W'(1);
      end
    end

    // Clear wins over a same-cycle hit; the counter saturates rather than wraps.
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q  <= MAX_LEN'(4'b1101);
      len_q  <= LEN_W'(4);
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
  assign cfg_len_q = len_q;

`ifdef SEQ_DET_PROG_REG_OUT_EN
  logic match_q, match_d;

  // hit is already forced low on a cfg_load cycle, which clears the flop.
  always_comb begin
    match_d = hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match = match_q;
`else
  assign match = hit;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: directed scenarios plus randomized traffic checked against a
// queue-based reference model; a second instance with CNT_W=2 exercises saturation.
module tb_seq_det_prog;

  localparam int unsigned MaxLen = 8;
  localparam int unsigned LenW   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_bit, cfg_load, cfg_overlap, cnt_clr;
  logic [MaxLen-1:0] cfg_pattern;
  logic [LenW-1:0]   cfg_len;
  logic              match, match2;
  logic [7:0]        match_cnt;
  logic [1:0]        match_cnt2;
  logic [LenW-1:0]   cfg_len_q, cfg_len_q2;

  int vectors = 0;
  int errors  = 0;

  // Reference model: bits accepted since the last restart, newest at the back.
  bit          q[$];
  logic [7:0]  m_pat;
  int          m_len;
  bit          m_ovl;
  int          m_cnt8, m_cnt2;
  bit          m_prev_hit;

  seq_det_prog #(.MAX_LEN(MaxLen), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .match(match), .match_cnt(match_cnt), .cfg_len_q(cfg_len_q)
  );

  seq_det_prog #(.MAX_LEN(MaxLen), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .match(match2), .match_cnt(match_cnt2), .cfg_len_q(cfg_len_q2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(input bit v, input bit b, input bit ld);
    bit x;
    if (!v || ld || m_len == 0) return 1'b0;
    if (q.size() + 1 < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      x = (i == 0) ? b : q[q.size() - i];
      if (x != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pat      = 8'b0000_1101;
    m_len      = 4;
    m_ovl      = 1'b1;
    m_cnt8     = 0;
    m_cnt2     = 0;
    m_prev_hit = 1'b0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input bit v, input bit b, input bit ld, input logic [7:0] p,
                      input logic [3:0] l, input bit o, input bit clr);
    bit h;
    in_valid    = v;
    in_bit      = b;
    cfg_load    = ld;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cnt_clr     = clr;
    #3;
    h = model_hit(v, b, ld);
`ifdef SEQ_DET_PROG_REG_OUT_EN
    check("match", match, 32'(m_prev_hit));
    check("match_w2", match2, 32'(m_prev_hit));
`else
    check("match", match, 32'(h));
    check("match_w2", match2, 32'(h));
`endif
    @(posedge clk);
    #1;
    if (ld) begin
      q.delete();
      m_pat = p;
      m_len = (int'(l) > MaxLen) ? MaxLen : int'(l);
      m_ovl = o;
    end else if (v) begin
      if (h && !m_ovl) begin
        q.delete();
      end else begin
        q.push_back(b);
        if (q.size() > MaxLen) void'(q.pop_front());
      end
    end
    if (clr) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (h) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    m_prev_hit = h;
    check("match_cnt", match_cnt, m_cnt8);
    check("match_cnt_w2", match_cnt2, m_cnt2);
    check("cfg_len_q", cfg_len_q, m_len);
  endtask

  task automatic send(input bit b);
    step(1'b1, b, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic bubble();
    step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
    step(1'b0, 1'b0, 1'b1, p, l, o, 1'b0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
    rst      = 1'b1;
    #2;
    model_reset();
    check("rst_match", match, 32'd0);
    check("rst_cnt", match_cnt, 32'd0);
    check("rst_len", cfg_len_q, 32'd4);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit stream7[7];
    stream7 = '{1, 1, 0, 1, 1, 0, 1};
    rst = 1'b1;
    in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0; cfg_overlap = 1'b0;
    cnt_clr = 1'b0; cfg_pattern = '0; cfg_len = '0;
    #1;
    do_reset();

    // Default 1101 with overlap: hits on bits 4 and 7.
    foreach (stream7[i]) send(stream7[i]);
    check("overlap_total", match_cnt, 32'd2);

    // Same stream without overlap: only bit 4 hits.
    load(8'b1101, 4'd4, 1'b0);
    foreach (stream7[i]) send(stream7[i]);
    check("no_overlap_total", match_cnt, 32'd3);

    // Bubbles between every bit are transparent.
    load(8'b1101, 4'd4, 1'b1);
    send(1); bubble(); send(1); bubble(); send(0); bubble(); send(1); bubble();

    // Load discards earlier history.
    send(1); send(1);
    load(8'b111, 4'd3, 1'b1);
    repeat (4) send(1);

    // Back-to-back hits, 2-bit counter saturates, then clear beside a hit.
    load(8'b1111, 4'd4, 1'b1);
    repeat (8) send(1);
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    check("clr_beats_hit", match_cnt2, 32'd0);

    // Length zero disables detection.
    load(8'h00, 4'd0, 1'b1);
    repeat (20) send(1'($urandom));

    // Clamp of oversize length.
    load(8'hA5, 4'd13, 1'b0);
    check("len_clamp", cfg_len_q, 32'd8);

    // Reset mid-stream discards the partial match.
    do_reset();
    send(1); send(1); send(0);
    do_reset();
    send(1); send(1); send(1); send(0); send(1);

    // Randomized configurations and traffic.
    for (int t = 0; t < 30; t++) begin
      load(8'($urandom), ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5)),
           1'($urandom));
      for (int k = 0; k < 40; k++) begin
        step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 80) == 0,
             8'($urandom), 4'($urandom_range(0, 5)), 1'($urandom),
             $urandom_range(0, 25) == 0);
      end
    end

    // 8-bit counter saturation.
    do_reset();
    load(8'b1111, 4'd4, 1'b1);
    repeat (265) send(1);
    check("cnt8_saturated", match_cnt, 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_prog.md
# seq_det_prog

Runtime-programmable serial bit-pattern detector, the parametrised successor to the team's fixed 4-bit Mealy detectors. It watches a qualified 1-bit stream for a pattern of 1..MAX_LEN bits. Pattern, length and overlap mode are loaded at run time. It produces a per-bit match strobe and a saturating match counter, and sits between a deserialiser front end and the control/status register bank.

## Interface
- MAX_LEN, 8: maximum pattern length in bits; legal range 4..32.
- CNT_W, 8: width of the match counter.
- LEN_W, $clog2(MAX_LEN+1): width of the length fields (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  qualifies in_bit for this cycle.
- in_bit  in  1  serial data bit.
- cfg_load  in  1  one-cycle strobe; latches the cfg_* fields.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is received first, bit [0] last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping detection; 0 = restart after each match.
- cnt_clr  in  1  synchronous clear of match_cnt.
- match  out  1  detection strobe.
- match_cnt  out  CNT_W  saturating count of matches.
- cfg_len_q  out  LEN_W  active (clamped) length, for readback.

## Operation
- Registers:
  - pat: MAX_LEN bits.
  - len: LEN_W bits.
  - ovl: 1 bit.
  - hist: MAX_LEN bits, shift register of accepted bits, newest in bit 0.
  - fill: LEN_W bits, count of accepted bits since last restart, saturating at len.
  - match_cnt.
- Reset values:
  - pat = 'b1101 (zero-extended), len = 4, ovl = 1.
  - hist = 0, fill = 0, match_cnt = 0, match = 0, cfg_len_q = 4.
- Accept: a cycle with in_valid=1 and cfg_load=0. Cycles with in_valid=0 change nothing (bubbles are transparent).
- Hit condition, evaluated on accept:
  - len != 0, and
  - fill >= len-1, and
  - the low len bits of {hist, in_bit} equal the low len bits of pat.
- On accept:
  - hist <= {hist[MAX_LEN-2:0], in_bit}.
  - If no hit, or hit with ovl=1: fill <= min(fill+1, len).
  - If hit with ovl=0: fill <= 0, so the next match needs len fresh bits.
- cfg_load:
  - pat <= cfg_pattern; ovl <= cfg_overlap.
  - len <= cfg_len, clamped to MAX_LEN if larger.
  - hist <= 0, fill <= 0.
  - in_bit is not accepted that cycle, and match = 0.
- len = 0: detector disabled. match is never asserted; hist and fill still update.
- match_cnt:
  - Increments by 1 on each hit; holds at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 forces 0 and takes priority over a same-cycle hit; that hit is not counted.
  - cnt_clr does not affect detection state.
- Reset mid-stream: everything returns to reset values immediately; a partial match is discarded.

## Timing
- Without the macro, match is Mealy: combinational from in_valid/in_bit and registered state, high in the same cycle as the completing bit.
- Detection latency: 0 cycles after the last pattern bit is presented.
- match_cnt reflects a hit on the next rising edge (1-cycle latency).
- cfg_load takes effect on the next edge. The first bit accepted after load is the bit presented in the following cycle.
- Maximum match rate: one per accepted bit with ovl=1 (e.g. pattern 1111 on an all-ones stream).

## Configuration
- SEQ_DET_PROG_REG_OUT_EN defined:
  - match is a flop, set from the hit condition, so it asserts exactly 1 cycle after the completing bit.
  - match resets to 0 and is cleared by cfg_load.
  - match_cnt timing is unchanged.
- Not defined: match is the combinational Mealy strobe described above.

## Test plan
- After reset (defaults 1101, overlap), bits 1,1,0,1,1,0,1 on consecutive valid cycles -> match high on bits 4 and 7; match_cnt = 2.
- cfg_load with pattern 1101, len 4, overlap 0, then the same 7-bit stream -> match only on bit 4; match_cnt increments by 1.
- Stream 1,1,0,1 with in_valid=0 bubbles between every bit -> single match on the 4th valid bit; no match in bubble cycles.
- cfg_load with pattern 'b111, len 3, overlap 1 after 2 ones already sent, then 4 ones -> matches on the 3rd and 4th post-load bits only (pre-load history discarded).
- CNT_W=2: 5 hits -> match_cnt 1,2,3,3,3. Then cnt_clr asserted in the same cycle as a hit -> match_cnt = 0.
- len=0 loaded, any stream -> match never asserts. Separately, rst pulsed after 1,1,0 -> the next 1 does not match; the subsequent 1,1,0,1 matches.
